// File: rtl/core_pkg.sv
// Shared definitions for the core controller and datapath.
// Holds the bus source codes (read_en), the strobe bit positions used in
// write_en / inc_en / clr_en, and the ALU operation codes.
package core_pkg;

    // write_en bit positions
    localparam int WE_PC  = 1;
    localparam int WE_AR  = 2;
    localparam int WE_IR  = 3;
    localparam int WE_AC  = 4;
    localparam int WE_R   = 5;
    localparam int WE_R4  = 7;
    localparam int WE_R3  = 8;
    localparam int WE_R2  = 9;
    localparam int WE_R1  = 10;
    localparam int WE_DM  = 11;
    localparam int WE_ALU = 12;

    // inc_en / clr_en bit positions
    localparam int INC_PC = 1;
    localparam int INC_AC = 4;
    localparam int CLR_PC = 1;
    localparam int CLR_AC = 4;

    // Width of the opcode field held in IR[5:0]
    localparam int OPCODE_W = 6;

    // read_en: which source drives the shared bus
    typedef enum logic [3:0] {
        SRC_NONE = 4'd0,
        SRC_PC   = 4'd1,
        SRC_AR   = 4'd2,
        SRC_IR   = 4'd4,
        SRC_AC   = 4'd5,
        SRC_R    = 4'd6,
        SRC_R1   = 4'd7,
        SRC_R2   = 4'd8,
        SRC_R3   = 4'd9,
        SRC_R4   = 4'd10,
        SRC_DM   = 4'd12,
        SRC_IM   = 4'd13
    } read_src_e;

    // alu_op codes
    typedef enum logic [2:0] {
        ALU_NONE = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_MUL  = 3'd3,
        ALU_SHL  = 3'd4
    } alu_op_e;

endpackage

// File: rtl/core_alu.sv
// Combinational ALU for the core datapath.
// Ports:
//   alu_op : operation code (core_pkg::alu_op_e values)
//   a, b   : operands (AC and R in the datapath)
//   y      : result, truncated to DATA_W; 0 for none/unused codes
module core_alu
    import core_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        case (alu_op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            // Result width is DATA_W, so only the low half of the product is kept.
            ALU_MUL: y = a * b;
            ALU_SHL: y = a << b[3:0];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/core_datapath.sv
// Single-bus accumulator datapath: PC, AR, IR, AC, R, R1-R4 and a
// two-cycle ALU path (cycle A latches the result in alu_q, cycle B moves
// alu_q into AC).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   alu_op              : ALU operation for cycle A (0 selects cycle B)
//   write_en            : per-register load strobes (bus -> register)
//   inc_en, clr_en      : increment / clear strobes for PC and AC
//   read_en             : bus source select
//   z                   : AC == 0
//   instruction         : opcode IR[5:0]
//   im_addr, im_rdata   : instruction memory (address = PC, async read)
//   dm_addr, dm_wdata,
//   dm_we, dm_rdata     : data memory (address = AR, data = bus)
module core_datapath
    import core_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          alu_op,
    input  logic [15:0]         write_en,
    input  logic [15:0]         inc_en,
    input  logic [15:0]         clr_en,
    input  logic [3:0]          read_en,
    output logic                z,
    output logic [5:0]          instruction,
    output logic [ADDR_W-1:0]   im_addr,
    input  logic [DATA_W-1:0]   im_rdata,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_we,
    input  logic [DATA_W-1:0]   dm_rdata
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] ac;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [DATA_W-1:0] r3;
    logic [DATA_W-1:0] r4;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] bus;
    logic              alu_cycle_a;
    logic              alu_cycle_b;

    // Strobe bits with no register behind them; collected so the intent
    // of leaving them unconnected is explicit.
    logic unused_strobes;
    assign unused_strobes = ^{write_en[15:13], write_en[6], write_en[0],
                              inc_en[15:5], inc_en[3:2], inc_en[0],
                              clr_en[15:5], clr_en[3:2], clr_en[0]};

    core_alu #(.DATA_W(DATA_W)) u_alu (
        .alu_op (alu_op),
        .a      (ac),
        .b      (r),
        .y      (alu_y)
    );

    // Shared bus; unused codes read as zero.
    always_comb begin
        bus = '0;
        case (read_en)
            SRC_PC:  bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
            SRC_AR:  bus = {{(DATA_W-ADDR_W){1'b0}}, ar};
            SRC_IR:  bus = {{OPCODE_W{1'b0}}, ir[DATA_W-1:OPCODE_W]};
            SRC_AC:  bus = ac;
            SRC_R:   bus = r;
            SRC_R1:  bus = r1;
            SRC_R2:  bus = r2;
            SRC_R3:  bus = r3;
            SRC_R4:  bus = r4;
            SRC_DM:  bus = dm_rdata;
            SRC_IM:  bus = im_rdata;
            default: bus = '0;
        endcase
    end

    assign alu_cycle_a = write_en[WE_ALU] &&
                         (alu_op inside {ALU_ADD, ALU_SUB, ALU_MUL, ALU_SHL});
    assign alu_cycle_b = write_en[WE_ALU] && (alu_op == ALU_NONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            ar    <= '0;
            ir    <= '0;
            ac    <= '0;
            r     <= '0;
            r1    <= '0;
            r2    <= '0;
            r3    <= '0;
            r4    <= '0;
            alu_q <= '0;
        end else begin
            if (clr_en[CLR_PC])      pc <= '0;
            else if (inc_en[INC_PC]) pc <= pc + ADDR_W'(1);
            else if (write_en[WE_PC]) pc <= bus[ADDR_W-1:0];

            // A bus load of AC wins over the cycle-B move from alu_q.
            if (clr_en[CLR_AC])       ac <= '0;
            else if (inc_en[INC_AC])  ac <= ac + DATA_W'(1);
            else if (write_en[WE_AC]) ac <= bus;
            else if (alu_cycle_b)     ac <= alu_q;

            if (write_en[WE_AR]) ar <= bus[ADDR_W-1:0];
            if (write_en[WE_IR]) ir <= bus;
            if (write_en[WE_R])  r  <= bus;
            if (write_en[WE_R1]) r1 <= bus;
            if (write_en[WE_R2]) r2 <= bus;
            if (write_en[WE_R3]) r3 <= bus;
            if (write_en[WE_R4]) r4 <= bus;

            if (alu_cycle_a) alu_q <= alu_y;
        end
    end

    assign z           = (ac == '0);
    assign instruction = ir[5:0];
    assign im_addr     = pc;
    assign dm_addr     = ar;
    assign dm_wdata    = bus;
    assign dm_we       = write_en[WE_DM];

endmodule

// File: tb/tb_core_datapath.sv
// Directed, table-driven bench for core_datapath. Each vector drives one
// clock edge's worth of strobes, then selects a bus source to observe the
// resulting register state through dm_wdata and compares it together with
// z, instruction, im_addr and dm_addr.
module tb_core_datapath;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    alu_op;
    logic [15:0]   write_en;
    logic [15:0]   inc_en;
    logic [15:0]   clr_en;
    logic [3:0]    read_en;
    logic          z;
    logic [5:0]    instruction;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_rdata;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_we;
    logic [DW-1:0] dm_rdata;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    core_datapath #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_op      (alu_op),
        .write_en    (write_en),
        .inc_en      (inc_en),
        .clr_en      (clr_en),
        .read_en     (read_en),
        .z           (z),
        .instruction (instruction),
        .im_addr     (im_addr),
        .im_rdata    (im_rdata),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_we       (dm_we),
        .dm_rdata    (dm_rdata)
    );

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic        rst;
        logic [2:0]  op;
        logic [15:0] we;
        logic [15:0] inc;
        logic [15:0] clr;
        logic [3:0]  rd;
        logic [15:0] dat;
        logic [3:0]  chk;
        logic [15:0] exp_bus;
        logic        exp_z;
        logic [5:0]  exp_instr;
        logic [9:0]  exp_pc;
        logic [9:0]  exp_ar;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string name, logic rst_v, logic [2:0] op,
                                logic [15:0] we, logic [15:0] inc, logic [15:0] clr,
                                logic [3:0] rd, logic [15:0] dat, logic [3:0] chk,
                                logic [15:0] exp_bus, logic exp_z, logic [5:0] exp_instr,
                                logic [9:0] exp_pc, logic [9:0] exp_ar);
        vec_t v;
        v.name = name; v.rst = rst_v; v.op = op; v.we = we; v.inc = inc; v.clr = clr;
        v.rd = rd; v.dat = dat; v.chk = chk; v.exp_bus = exp_bus; v.exp_z = exp_z;
        v.exp_instr = exp_instr; v.exp_pc = exp_pc; v.exp_ar = exp_ar;
        vecs.push_back(v);
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst_v, logic [2:0] op, logic [15:0] we,
                         logic [15:0] inc, logic [15:0] clr, logic [3:0] rd,
                         logic [15:0] dat);
        rst = rst_v; alu_op = op; write_en = we; inc_en = inc; clr_en = clr;
        read_en = rd; im_rdata = dat; dm_rdata = dat;
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        drive(v.rst, v.op, v.we, v.inc, v.clr, v.rd, v.dat);
        @(posedge clk);
        #2;
        read_en = v.chk;
        #1;
        check({v.name, ".bus"},   dm_wdata, v.exp_bus);
        check({v.name, ".z"},     16'(z), 16'(v.exp_z));
        check({v.name, ".instr"}, 16'(instruction), 16'(v.exp_instr));
        check({v.name, ".pc"},    16'(im_addr), 16'(v.exp_pc));
        check({v.name, ".ar"},    16'(dm_addr), 16'(v.exp_ar));
    endtask

    // Strobe masks and read codes, written out numerically.
    localparam logic [15:0] M_PC = 16'h0002, M_AR = 16'h0004, M_IR = 16'h0008,
                            M_AC = 16'h0010, M_R  = 16'h0020, M_RX = 16'h07A0,
                            M_DM = 16'h0800, M_AL = 16'h1000;
    localparam logic [3:0]  C_PC = 4'd1, C_AR = 4'd2, C_IO = 4'd4, C_AC = 4'd5,
                            C_R = 4'd6, C_R1 = 4'd7, C_R2 = 4'd8, C_R3 = 4'd9,
                            C_R4 = 4'd10, C_DM = 4'd12, C_IM = 4'd13;

    initial begin
        drive(1'b1, 3'd0, 16'h0, 16'h0, 16'h0, 4'd0, 16'h0);

        //   name            rst op  we         inc      clr      rd    dat       chk   bus       z  instr  pc      ar
        add("reset",         1, 0, 0,         0,       0,       0,    0,        C_AC, 16'h0000, 1, 6'h00, 10'h0,  10'h0);
        add("ld_pc",         0, 0, M_PC,      0,       0,       C_DM, 16'h0003, C_PC, 16'h0003, 1, 6'h00, 10'h3,  10'h0);
        add("fetch_ir",      0, 0, M_IR,      0,       0,       C_IM, 16'h0153, C_IO, 16'h0005, 1, 6'h13, 10'h3,  10'h0);
        add("ld_ar",         0, 0, M_AR,      0,       0,       C_DM, 16'h0007, C_AR, 16'h0007, 1, 6'h13, 10'h3,  10'h7);
        add("ld_ac",         0, 0, M_AC,      0,       0,       C_DM, 16'h00A5, C_AC, 16'h00A5, 0, 6'h13, 10'h3,  10'h7);
        add("multi_r1",      0, 0, M_RX,      0,       0,       C_AC, 16'h0000, C_R1, 16'h00A5, 0, 6'h13, 10'h3,  10'h7);
        add("multi_r2",      0, 0, 0,         0,       0,       0,    16'h0000, C_R2, 16'h00A5, 0, 6'h13, 10'h3,  10'h7);
        add("multi_r3",      0, 0, 0,         0,       0,       0,    16'h0000, C_R3, 16'h00A5, 0, 6'h13, 10'h3,  10'h7);
        add("multi_r4",      0, 0, 0,         0,       0,       0,    16'h0000, C_R4, 16'h00A5, 0, 6'h13, 10'h3,  10'h7);
        add("multi_r",       0, 0, 0,         0,       0,       0,    16'h0000, C_R,  16'h00A5, 0, 6'h13, 10'h3,  10'h7);
        add("rd_im",         0, 0, 0,         0,       0,       0,    16'hBEEF, C_IM, 16'hBEEF, 0, 6'h13, 10'h3,  10'h7);
        add("ld_ac6",        0, 0, M_AC,      0,       0,       C_DM, 16'h0006, C_AC, 16'h0006, 0, 6'h13, 10'h3,  10'h7);
        add("ld_r7",         0, 0, M_R,       0,       0,       C_DM, 16'h0007, C_R,  16'h0007, 0, 6'h13, 10'h3,  10'h7);
        add("mul_a",         0, 3, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h0006, 0, 6'h13, 10'h3,  10'h7);
        add("mul_b",         0, 0, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h002A, 0, 6'h13, 10'h3,  10'h7);
        add("ld_ac5",        0, 0, M_AC,      0,       0,       C_DM, 16'h0005, C_AC, 16'h0005, 0, 6'h13, 10'h3,  10'h7);
        add("ld_r5",         0, 0, M_R,       0,       0,       C_DM, 16'h0005, C_R,  16'h0005, 0, 6'h13, 10'h3,  10'h7);
        add("sub_a",         0, 2, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h0005, 0, 6'h13, 10'h3,  10'h7);
        add("sub_b",         0, 0, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h0000, 1, 6'h13, 10'h3,  10'h7);
        add("ld_ac3",        0, 0, M_AC,      0,       0,       C_DM, 16'h0003, C_AC, 16'h0003, 0, 6'h13, 10'h3,  10'h7);
        add("add_a",         0, 1, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h0003, 0, 6'h13, 10'h3,  10'h7);
        add("add_b",         0, 0, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h0008, 0, 6'h13, 10'h3,  10'h7);
        add("shl_a",         0, 4, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h0008, 0, 6'h13, 10'h3,  10'h7);
        add("shl_b",         0, 0, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h0100, 0, 6'h13, 10'h3,  10'h7);
        add("ld_r0103",      0, 0, M_R,       0,       0,       C_DM, 16'h0103, C_R,  16'h0103, 0, 6'h13, 10'h3,  10'h7);
        add("mul2_a",        0, 3, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h0100, 0, 6'h13, 10'h3,  10'h7);
        add("mul2_trunc",    0, 0, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h0300, 0, 6'h13, 10'h3,  10'h7);
        add("shl2_a",        0, 4, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h0300, 0, 6'h13, 10'h3,  10'h7);
        add("shl2_low4",     0, 0, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h1800, 0, 6'h13, 10'h3,  10'h7);
        add("add2_a",        0, 1, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h1800, 0, 6'h13, 10'h3,  10'h7);
        add("bus_over_alu",  0, 0, M_AC|M_AL, 0,       0,       C_DM, 16'h1234, C_AC, 16'h1234, 0, 6'h13, 10'h3,  10'h7);
        add("alu_q_kept",    0, 0, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h1903, 0, 6'h13, 10'h3,  10'h7);
        add("ld_acffff",     0, 0, M_AC,      0,       0,       C_DM, 16'hFFFF, C_AC, 16'hFFFF, 0, 6'h13, 10'h3,  10'h7);
        add("ac_inc_wrap",   0, 0, 0,         M_AC,    0,       0,    16'h0000, C_AC, 16'h0000, 1, 6'h13, 10'h3,  10'h7);
        add("ld_ac42",       0, 0, M_AC,      0,       0,       C_DM, 16'h0042, C_AC, 16'h0042, 0, 6'h13, 10'h3,  10'h7);
        add("ac_clr_inc",    0, 0, M_AC,      M_AC,    M_AC,    C_DM, 16'h0077, C_AC, 16'h0000, 1, 6'h13, 10'h3,  10'h7);
        add("ac_inc_wr",     0, 0, M_AC,      M_AC,    0,       C_DM, 16'h0077, C_AC, 16'h0001, 0, 6'h13, 10'h3,  10'h7);
        add("ld_pc9",        0, 0, M_PC,      0,       0,       C_DM, 16'h0009, C_PC, 16'h0009, 0, 6'h13, 10'h9,  10'h7);
        add("pc_clr_inc",    0, 0, M_PC,      M_PC,    M_PC,    C_DM, 16'h0055, C_PC, 16'h0000, 0, 6'h13, 10'h0,  10'h7);
        add("pc_inc_wr",     0, 0, M_PC,      M_PC,    0,       C_DM, 16'h0055, C_PC, 16'h0001, 0, 6'h13, 10'h1,  10'h7);
        add("pc_trunc",      0, 0, M_PC,      0,       0,       C_DM, 16'hFFFF, C_PC, 16'h03FF, 0, 6'h13, 10'h3FF, 10'h7);
        add("pc_inc_wrap",   0, 0, 0,         M_PC,    0,       0,    16'h0000, C_PC, 16'h0000, 0, 6'h13, 10'h0,  10'h7);
        add("ar_trunc",      0, 0, M_AR,      0,       0,       C_DM, 16'hF407, C_AR, 16'h0007, 0, 6'h13, 10'h0,  10'h7);
        add("rd_code14",     0, 0, 0,         0,       0,       0,    16'h0000, 4'd14, 16'h0000, 0, 6'h13, 10'h0, 10'h7);
        add("illegal_rd",    0, 0, M_AC,      0,       0,       4'd3, 16'h0077, C_AC, 16'h0000, 1, 6'h13, 10'h0,  10'h7);
        add("ld_ac5b",       0, 0, M_AC,      0,       0,       C_DM, 16'h0005, C_AC, 16'h0005, 0, 6'h13, 10'h0,  10'h7);
        add("ld_r2",         0, 0, M_R,       0,       0,       C_DM, 16'h0002, C_R,  16'h0002, 0, 6'h13, 10'h0,  10'h7);
        add("add3_a",        0, 1, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h0005, 0, 6'h13, 10'h0,  10'h7);
        add("rst_mid_alu",   1, 0, M_AC|M_AL, M_PC,    0,       C_DM, 16'h0077, C_AC, 16'h0000, 1, 6'h00, 10'h0,  10'h0);
        add("b_after_rst",   0, 0, M_AL,      0,       0,       0,    16'h0000, C_AC, 16'h0000, 1, 6'h00, 10'h0,  10'h0);
        add("r_cleared",     0, 0, 0,         0,       0,       0,    16'h0000, C_R,  16'h0000, 1, 6'h00, 10'h0,  10'h0);
        add("r1_cleared",    0, 0, 0,         0,       0,       0,    16'h0000, C_R1, 16'h0000, 1, 6'h00, 10'h0,  10'h0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // ---- store sequence: AR=7, AC=0xA5, then put AC on the bus with DM write ----
        @(negedge clk);
        drive(1'b0, 3'd0, M_AR, 16'h0, 16'h0, C_DM, 16'h0007);
        @(negedge clk);
        drive(1'b0, 3'd0, M_AC, 16'h0, 16'h0, C_DM, 16'h00A5);
        @(negedge clk);
        drive(1'b0, 3'd0, M_DM, 16'h0, 16'h0, C_AC, 16'h0000);
        #1;
        check("store.dm_we",    16'(dm_we), 16'h0001);
        check("store.dm_addr",  16'(dm_addr), 16'h0007);
        check("store.dm_wdata", dm_wdata, 16'h00A5);
        check("store.z",        16'(z), 16'h0000);

        // dm_we drops as soon as bit 11 does, with no edge in between.
        write_en = M_AC;
        #1;
        check("store.dm_we_off", 16'(dm_we), 16'h0000);

        // dm_we follows write_en even while reset is asserted.
        @(negedge clk);
        drive(1'b1, 3'd0, M_DM, 16'h0, 16'h0, C_AC, 16'h0000);
        #1;
        check("rst.dm_we", 16'(dm_we), 16'h0001);
        @(posedge clk);
        #1;
        check("rst.ac_bus", dm_wdata, 16'h0000);
        check("rst.z",      16'(z), 16'h0001);

        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 4'd0, 16'h0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/core_datapath.md
CORE_DATAPATH -- requirements
Module: core_datapath

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of bus, AC, R, R1-R4, IR and data memory words.
REQ-002 SHALL have parameter ADDR_W, default 10, width of PC, AR, im_addr and dm_addr.
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port alu_op  in  3  ALU operation: 0 none, 1 add, 2 sub, 3 mult, 4 lshift.
REQ-006 SHALL have port write_en  in  16  load strobes: bit1 PC, bit2 AR, bit3 IR, bit4 AC, bit5 R, bit7 R4, bit8 R3, bit9 R2, bit10 R1, bit11 DM, bit12 ALU path; other bits ignored.
REQ-007 SHALL have port inc_en  in  16  increment strobes: bit1 PC, bit4 AC; other bits ignored.
REQ-008 SHALL have port clr_en  in  16  clear strobes: bit1 PC, bit4 AC; other bits ignored.
REQ-009 SHALL have port read_en  in  4  bus source: 1 PC, 2 AR, 4 IR operand, 5 AC, 6 R, 7 R1, 8 R2, 9 R3, 10 R4, 12 DM, 13 IM; other codes drive 0.
REQ-010 SHALL have port z  out  1  high when AC equals 0.
REQ-011 SHALL have port instruction  out  6  opcode, IR[5:0].
REQ-012 SHALL have ports im_addr out ADDR_W (= PC) and im_rdata in DATA_W (combinational-read instruction memory).
REQ-013 SHALL have ports dm_addr out ADDR_W (= AR), dm_wdata out DATA_W (= bus), dm_we out 1, and dm_rdata in DATA_W (combinational-read data memory).

Function
REQ-014 Bus SHALL be combinational from read_en and register state; IR operand = IR[DATA_W-1:6] zero-extended.
REQ-015 Bus values SHALL be truncated to ADDR_W when loaded into PC or AR.
REQ-016 Every register whose write_en bit is set SHALL load the bus on the next edge; multiple simultaneous loads are legal.
REQ-017 Per register, priority SHALL be clr > inc > write.
REQ-018 PC and AC increments SHALL wrap modulo 2^width; AC 0xFFFF+1 gives 0 and z=1.
REQ-019 dm_we SHALL equal write_en[11] combinationally; the external memory stores dm_wdata at dm_addr on that edge.
REQ-020 ALU path, cycle A: write_en[12]=1 with alu_op 1-4 SHALL latch f(AC,R) into internal register alu_q.
REQ-021 ALU path, cycle B: write_en[12]=1 with alu_op=0 SHALL load alu_q into AC; AC therefore updates 2 edges after cycle A starts.
REQ-022 ALU ops: add AC+R, sub AC-R two's complement, mult low DATA_W bits of AC*R, lshift AC<<R[3:0]; all results truncated to DATA_W.
REQ-023 Write to AC from the bus (bit4) SHALL take precedence over the cycle-B ALU load (bit12) in the same cycle.
REQ-024 z SHALL be derived from the registered AC, valid the cycle after any AC change.
REQ-025 Illegal read_en codes SHALL NOT raise errors; the bus reads 0.

Reset
REQ-026 On rst=1 at an edge, PC, AR, IR, AC, R, R1-R4 and alu_q SHALL become 0; z=1, instruction=0, dm_we follows write_en.
REQ-027 rst SHALL override all strobes in the same cycle, including mid-ALU sequence (alu_q discarded).

Structure
REQ-028 Shared package core_pkg SHALL hold read_en source codes, write_en/inc_en/clr_en bit indices, and alu_op codes, for use by both the controller and this block.
REQ-029 ALU arithmetic SHALL be a combinational sub-module core_alu(alu_op, a, b, y); alu_q lives in core_datapath.

Verification
REQ-030 Fetch: PC=3, im_rdata=0x0153, read_en=13, write_en bit3 -> IR=0x0153, instruction=0x13, bus on read_en=4 = 0x0005.
REQ-031 Load/store: AR=7, dm_rdata=0x00A5, read_en=12, write_en bit4 -> AC=0x00A5, z=0; then read_en=5, write_en bit11 -> dm_we=1, dm_addr=7, dm_wdata=0x00A5.
REQ-032 ALU: AC=6, R=7; alu_op=3 with bit12, then alu_op=0 with bit12 -> AC=42 after second edge and not before; sub with AC=5, R=5 -> AC=0, z=1.
REQ-033 Counters: AC=0xFFFF, inc_en bit4 -> AC=0, z=1; same cycle clr_en bit1 and inc_en bit1 on PC=9 -> PC=0.
REQ-034 Reset mid-op: alu_op=1 cycle A, rst=1 on next edge -> AC=0, alu_q=0; a following cycle-B load leaves AC=0.
